// File: rtl/writeback_arbiter_if.sv
// Writeback bus between the execution units and the writeback arbiter:
// per-unit result requests in, one registered writeback beat out.
interface writeback_arbiter_if #(
  parameter int NUM_REQ            = 4,
  parameter int LOG_NUM_REQ        = $clog2(NUM_REQ),
  parameter int PHYS_REG_WIDTH     = 6,
  parameter int ROB_INDEX_WIDTH    = 5,
  parameter int CONFLICT_CNT_WIDTH = 16
);
  logic [NUM_REQ-1:0]                      req_valid;
  logic [NUM_REQ-1:0]                      req_reg_write;
  logic [NUM_REQ-1:0][PHYS_REG_WIDTH-1:0]  req_phys_reg_tag;
  logic [NUM_REQ-1:0][31:0]                req_data;
  logic [NUM_REQ-1:0][ROB_INDEX_WIDTH-1:0] req_ROB_index;
  logic                                    flush;
  logic [NUM_REQ-1:0]                      req_ready;

  logic                                    wb_valid;
  logic                                    wb_reg_write;
  logic [PHYS_REG_WIDTH-1:0]               wb_phys_reg_tag;
  logic [31:0]                             wb_data;
  logic [ROB_INDEX_WIDTH-1:0]              wb_ROB_index;
  logic [LOG_NUM_REQ-1:0]                  wb_source;
  logic [CONFLICT_CNT_WIDTH-1:0]           conflict_count;

  modport master (
    output req_valid, req_reg_write, req_phys_reg_tag, req_data, req_ROB_index, flush,
    input  req_ready, wb_valid, wb_reg_write, wb_phys_reg_tag, wb_data, wb_ROB_index,
           wb_source, conflict_count
  );

  modport slave (
    input  req_valid, req_reg_write, req_phys_reg_tag, req_data, req_ROB_index, flush,
    output req_ready, wb_valid, wb_reg_write, wb_phys_reg_tag, wb_data, wb_ROB_index,
           wb_source, conflict_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the phys-reg-file write port and ROB complete
// bus among ALU_0, ALU_1, LQ and BRU; the winner is registered onto the bus.
module writeback_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int LOG_NUM_REQ        = $clog2(NUM_REQ),
  parameter int PHYS_REG_WIDTH     = 6,
  parameter int ROB_INDEX_WIDTH    = 5,
  parameter int CONFLICT_CNT_WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  writeback_arbiter_if.slave bus
);

  logic [LOG_NUM_REQ-1:0]        rr_ptr;
  logic [LOG_NUM_REQ-1:0]        win_idx;
  logic [LOG_NUM_REQ-1:0]        next_ptr;
  logic                          win_found;
  logic                          transfer;
  logic                          others_valid;
  logic [NUM_REQ-1:0]            win_mask;
  logic [NUM_REQ-1:0]            ready;
  int                            scan_idx;

  logic                          wb_valid;
  logic                          wb_reg_write;
  logic [PHYS_REG_WIDTH-1:0]     wb_phys_reg_tag;
  logic [31:0]                   wb_data;
  logic [ROB_INDEX_WIDTH-1:0]    wb_ROB_index;
  logic [LOG_NUM_REQ-1:0]        wb_source;
  logic [CONFLICT_CNT_WIDTH-1:0] conflict_count;

  // Round-robin search: scanning offsets high to low lets the closest one to rr_ptr win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = LOG_NUM_REQ'(scan_idx);
      end else begin
        win_found = win_found;
      end
    end
  end

  // Grant decode, conflict detection and pointer advance.
  always_comb begin
    win_mask           = '0;
    win_mask[win_idx]  = 1'b1;
    transfer           = win_found & ~bus.flush & ~RST;
    others_valid       = |(bus.req_valid & ~win_mask);
    if (transfer) begin
      ready = win_mask;
    end else begin
      ready = '0;
    end
    if (win_idx == LOG_NUM_REQ'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = win_idx + LOG_NUM_REQ'(1);
    end
  end

  // Writeback register: load the winner, otherwise drop valid and hold payload.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_valid        <= 1'b0;
      wb_reg_write    <= 1'b0;
      wb_phys_reg_tag <= '0;
      wb_data         <= 32'd0;
      wb_ROB_index    <= '0;
      wb_source       <= '0;
    end else if (transfer) begin
      wb_valid        <= 1'b1;
      wb_reg_write    <= bus.req_reg_write[win_idx];
      wb_phys_reg_tag <= bus.req_phys_reg_tag[win_idx];
      wb_data         <= bus.req_data[win_idx];
      wb_ROB_index    <= bus.req_ROB_index[win_idx];
      wb_source       <= win_idx;
    end else begin
      wb_valid        <= 1'b0;
    end
  end

  // Round-robin pointer; flush suppresses the transfer so it never moves here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= next_ptr;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  // Saturating count of grant cycles in which some other unit was left waiting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      conflict_count <= '0;
    end else if (transfer && others_valid && (conflict_count != '1)) begin
      conflict_count <= conflict_count + CONFLICT_CNT_WIDTH'(1);
    end else begin
      conflict_count <= conflict_count;
    end
  end

  assign bus.req_ready       = ready;
  assign bus.wb_valid        = wb_valid;
  assign bus.wb_reg_write    = wb_reg_write;
  assign bus.wb_phys_reg_tag = wb_phys_reg_tag;
  assign bus.wb_data         = wb_data;
  assign bus.wb_ROB_index    = wb_ROB_index;
  assign bus.wb_source       = wb_source;
  assign bus.conflict_count  = conflict_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter against a queue-free behavioural
// model of pending unit results, plus the directed scenarios of interest.
module tb_writeback_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  writeback_arbiter_if #(.NUM_REQ(4), .PHYS_REG_WIDTH(6), .ROB_INDEX_WIDTH(5),
                         .CONFLICT_CNT_WIDTH(16)) bus ();

  writeback_arbiter #(.NUM_REQ(4), .PHYS_REG_WIDTH(6), .ROB_INDEX_WIDTH(5),
                      .CONFLICT_CNT_WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // unit-side state: outstanding results and their payloads
  logic [3:0]  pend;
  logic [5:0]  tag_a  [4];
  logic [31:0] data_a [4];
  logic [4:0]  rob_a  [4];
  logic        rw_a   [4];
  logic        flush_v;

  // expected bus state
  int          m_ptr;
  logic        m_valid, m_rw;
  logic [5:0]  m_tag;
  logic [31:0] m_data;
  logic [4:0]  m_rob;
  logic [1:0]  m_src;
  logic [15:0] m_conf;
  int          last_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic new_req(input int i, input logic rw, input logic [5:0] t,
                         input logic [31:0] d, input logic [4:0] r);
    pend[i] = 1'b1; rw_a[i] = rw; tag_a[i] = t; data_a[i] = d; rob_a[i] = r;
  endtask

  task automatic new_rand(input int i);
    new_req(i, 1'($urandom), 6'($urandom), $urandom, 5'($urandom));
  endtask

  task automatic drive();
    bus.req_valid = pend;
    bus.flush     = flush_v;
    for (int i = 0; i < 4; i++) begin
      bus.req_reg_write[i]    = rw_a[i];
      bus.req_phys_reg_tag[i] = tag_a[i];
      bus.req_data[i]         = data_a[i];
      bus.req_ROB_index[i]    = rob_a[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_rw = 1'b0; m_tag = 6'd0; m_data = 32'd0;
    m_rob = 5'd0; m_src = 2'd0; m_conf = 16'd0;
  endtask

  // called at a falling edge with inputs driven; returns at the next falling edge
  task automatic step();
    int w;
    logic [3:0] er;
    #1;
    w = -1;
    if (!RST && !flush_v) w = model_winner(pend, m_ptr);
    er = 4'b0000;
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(er));
    @(posedge CLK);
    if (w >= 0) begin
      m_valid = 1'b1; m_rw = rw_a[w]; m_tag = tag_a[w]; m_data = data_a[w];
      m_rob = rob_a[w]; m_src = 2'(w);
      if ((pend & ~er) != 4'b0000 && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
      m_ptr = (w + 1) % 4;
      pend[w] = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    last_w = w;
    @(negedge CLK);
    check("wb_valid", 64'(bus.wb_valid), 64'(m_valid));
    check("wb_reg_write", 64'(bus.wb_reg_write), 64'(m_rw));
    check("wb_tag", 64'(bus.wb_phys_reg_tag), 64'(m_tag));
    check("wb_data", 64'(bus.wb_data), 64'(m_data));
    check("wb_rob", 64'(bus.wb_ROB_index), 64'(m_rob));
    check("wb_source", 64'(bus.wb_source), 64'(m_src));
    check("conflict", 64'(bus.conflict_count), 64'(m_conf));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pend = 4'b0000; flush_v = 1'b0;
    for (int i = 0; i < 4; i++) new_req(i, 1'b0, 6'd0, 32'd0, 5'd0);
    pend = 4'b0000;
    model_reset();
    drive();
    repeat (2) @(negedge CLK);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_conflict", 64'(bus.conflict_count), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_wb_data", 64'(bus.wb_data), 64'd0);
    RST = 1'b0;
  endtask

  initial begin
    pend = 4'b0000; flush_v = 1'b0;
    do_reset();

    // all four continuously valid: strict 0,1,2,3 rotation, every grant a conflict
    for (int i = 0; i < 4; i++) new_rand(i);
    for (int k = 0; k < 8; k++) begin
      drive(); step();
      check("rr_order", 64'(bus.wb_source), 64'(k % 4));
      if (last_w >= 0) new_rand(last_w);
    end
    check("conflict_8", 64'(bus.conflict_count), 64'd8);
    pend = 4'b0000;

    // lone LQ request
    new_req(2, 1'b1, 6'd40, 32'hDEADBEEF, 5'd3);
    drive(); step();
    check("lq_src", 64'(bus.wb_source), 64'd2);
    check("lq_data", 64'(bus.wb_data), 64'hDEADBEEF);

    // wrap from pointer 3 back to 0
    new_rand(0); new_rand(3);
    drive(); step();
    check("wrap_src3", 64'(bus.wb_source), 64'd3);
    drive(); step();
    check("wrap_src0", 64'(bus.wb_source), 64'd0);

    // BRU completion without register write
    new_req(3, 1'b0, 6'd9, 32'h1234, 5'd17);
    drive(); step();
    check("bru_rw", 64'(bus.wb_reg_write), 64'd0);
    check("bru_rob", 64'(bus.wb_ROB_index), 64'd17);

    // flush right after granting unit 1
    new_rand(1);
    drive(); step();
    check("fl_src1", 64'(bus.wb_source), 64'd1);
    check("fl_valid_n1", 64'(bus.wb_valid), 64'd1);
    for (int i = 0; i < 4; i++) new_rand(i);
    flush_v = 1'b1;
    drive(); step();
    check("fl_valid_n2", 64'(bus.wb_valid), 64'd0);
    flush_v = 1'b0;
    drive(); #1;
    check("fl_regrant", 64'(bus.req_ready), 64'h4);
    step();

    // asynchronous reset between edges while a result is on the bus
    pend = 4'b0000;
    new_rand(1);
    drive(); step();
    check("ar_pre_valid", 64'(bus.wb_valid), 64'd1);
    new_rand(2); new_rand(3);
    drive(); #2;
    RST = 1'b1; #1;
    check("ar_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("ar_ready", 64'(bus.req_ready), 64'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    drive(); step();
    check("ar_first", 64'(bus.wb_source), 64'd2);

    // randomized traffic with occasional flushes; units may kill results on flush
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) new_rand(i);
      end
      flush_v = ($urandom_range(0, 9) == 0);
      drive(); step();
      if (flush_v) pend = pend & 4'($urandom);
    end
    flush_v = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single physical-register-file write port and ROB complete bus among the execution units: ALU_0, ALU_1, LQ and BRU.
- Arbitrates round-robin and registers the winner onto the writeback bus with 1-cycle latency.
- The writeback bus feeds the phys reg reg file, the phys reg ready table and ROB completion.
- A flush input squashes in-flight writeback on ROB restore/revert.

Parameters:
- NUM_REQ, 4, number of requesting units; index 0=ALU_0, 1=ALU_1, 2=LQ, 3=BRU.
- LOG_NUM_REQ, $clog2(NUM_REQ), width of the source/pointer fields.
- PHYS_REG_WIDTH, 6, physical register tag width (64 phys regs).
- ROB_INDEX_WIDTH, 5, ROB index width (LOG_ROB_DEPTH+1, including the pointer msb).
- CONFLICT_CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-unit result-available.
- req_reg_write  in  NUM_REQ  per-unit: result writes a physical register.
- req_phys_reg_tag  in  NUM_REQ x PHYS_REG_WIDTH  per-unit destination physical register.
- req_data  in  NUM_REQ x 32  per-unit result word.
- req_ROB_index  in  NUM_REQ x ROB_INDEX_WIDTH  per-unit ROB entry to complete.
- flush  in  1  ROB restore/revert; squash all writeback activity.
- req_ready  out  NUM_REQ  per-unit grant (combinational).
- wb_valid  out  1  writeback bus valid.
- wb_reg_write  out  1  write phys reg file and ready table.
- wb_phys_reg_tag  out  PHYS_REG_WIDTH  destination tag.
- wb_data  out  32  result word.
- wb_ROB_index  out  ROB_INDEX_WIDTH  ROB entry to mark complete.
- wb_source  out  LOG_NUM_REQ  winning unit index.
- conflict_count  out  CONFLICT_CNT_WIDTH  count of cycles in which one or more valid requesters lost arbitration.

Behaviour:
- Reset (RST=1, asynchronous):
  - rr_ptr=0, wb_valid=0, wb_reg_write=0.
  - wb_phys_reg_tag=0, wb_data=0, wb_ROB_index=0, wb_source=0.
  - conflict_count=0.
  - req_ready is all-zero while RST is asserted.
- Arbitration (combinational, each cycle):
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - No valid requester means req_ready is all-zero.
  - flush=1 forces req_ready all-zero.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A requester holds valid and its payload stable until granted.
  - req_ready never depends on the requester's own payload.
  - A requester may drop valid only after a transfer, or on flush.
- Writeback register:
  - On a transfer with no flush, the next edge loads: wb_valid=1, wb_reg_write, tag, data, ROB_index from the winner, and wb_source=winner.
  - Otherwise the next edge sets wb_valid=0 and the payload fields hold their previous values.
  - Latency: 1 cycle from grant to wb_valid.
  - Throughput: 1 result per cycle.
  - wb_valid is high for exactly one cycle per transfer.
- reg_write=0 (BRU, SC-fail, etc.): still produces wb_valid=1 for ROB completion, with wb_reg_write=0. Consumers ignore the tag and data.
- Pointer:
  - On a transfer, rr_ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
  - With no transfer, rr_ptr holds.
  - flush does not move rr_ptr.
- Flush:
  - The same edge clears wb_valid, so a result granted in the previous cycle still appears on the bus this cycle, but nothing is granted during the flush cycle.
  - Units are responsible for killing their own squashed results.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles, absent flush.
- Conflict counter: increments when a transfer occurs and one or more other req_valid bits are 1. It saturates at all-ones and does not wrap.
- Simultaneous flush and RST: RST dominates.

Test Plan:
- Single requester: req_valid=4'b0100 (LQ), tag=6'd40, data=32'hDEADBEEF, ROB=5'd3, reg_write=1 -> req_ready=4'b0100. Next cycle: wb_valid=1, wb_source=2, tag=40, data=DEADBEEF, ROB=3. rr_ptr becomes 3.
- All four held valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3. wb_valid high on all 8 cycles. conflict_count=8 at end (each of the 8 grants had other requesters still valid).
- Wrap: rr_ptr=3, req_valid=4'b1001 -> unit 3 is granted, rr_ptr becomes 0. Next cycle unit 0 is granted, rr_ptr becomes 1.
- BRU completion with req_reg_write=0, ROB=5'd17 -> wb_valid=1, wb_reg_write=0, wb_ROB_index=17.
- Flush:
  - Grant unit 1 in cycle N, assert flush in N+1 with req_valid=4'b1111 -> wb_valid=1 in N+1 (unit 1 result).
  - In N+1: req_ready=0 and rr_ptr stays at 2.
  - In N+2: wb_valid=0.
  - In N+2 (flush low): unit 2 is granted.
- Async reset mid-stream: assert RST between edges while wb_valid=1 -> wb_valid=0 and req_ready=0 immediately. After release, the first grant goes to the lowest valid index (rr_ptr=0).
